// File: rtl/game_input_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_input_controller
// Purpose  : N-player joystick/button front end for the Pacman top level.
//            Each raw input goes through a 2-FF synchroniser and a per-bit
//            debouncer. The debounced levels drive a per-player direction
//            latch with a registered change pulse, and a shared pause toggle.
// Options  : define GAME_INPUT_IDLE_EN to build per-player inactivity
//            counters. When it is undefined, idle is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module game_input_controller #(
   parameter int NUM_PLAYERS     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18,
   parameter int IDLE_CYCLES     = 50000000
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [NUM_PLAYERS-1:0]     joy_n,
   input  logic [NUM_PLAYERS-1:0]     joy_s,
   input  logic [NUM_PLAYERS-1:0]     joy_e,
   input  logic [NUM_PLAYERS-1:0]     joy_w,
   input  logic [NUM_PLAYERS-1:0]     pause_btn,
   output logic [2*NUM_PLAYERS-1:0]   direction,
   output logic [NUM_PLAYERS-1:0]     dir_changed,
   output logic                       paused,
   output logic                       pause_pulse,
   output logic [NUM_PLAYERS-1:0]     idle
);

   // All raw inputs are handled as one flat vector.
   // Bit index = source*NUM_PLAYERS + player.
   localparam int NB    = 5 * NUM_PLAYERS;
   localparam int SRC_E = 0;
   localparam int SRC_S = 1;
   localparam int SRC_W = 2;
   localparam int SRC_N = 3;
   localparam int SRC_P = 4;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] DIR_E = 2'b00;
   localparam logic [1:0] DIR_S = 2'b01;
   localparam logic [1:0] DIR_W = 2'b10;
   localparam logic [1:0] DIR_N = 2'b11;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_PAUSED = 1'b1;

   logic [NB-1:0]              w_raw;
   logic [NB-1:0]              r_s1;
   logic [NB-1:0]              r_s2;
   logic [NB-1:0]              r_db;
   logic [CNT_W-1:0]           r_cnt [NB];

   logic [2*NUM_PLAYERS-1:0]   w_dir_next;
   logic [NUM_PLAYERS-1:0]     w_dir_chg;
   logic [2*NUM_PLAYERS-1:0]   r_dir;
   logic [NUM_PLAYERS-1:0]     r_dir_chg;

   logic [NUM_PLAYERS-1:0]     w_pause_db;
   logic [NUM_PLAYERS-1:0]     r_pause_prev;
   logic                       w_pause_rise;
   logic [0:0]                 r_state;
   logic                       r_pause_pulse;

   assign w_raw = {pause_btn, joy_n, joy_w, joy_s, joy_e};

   // Two-flop synchroniser for every asynchronous input bit.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   // Debouncer. A new level is accepted only after it has differed from the
   // stable level for DEBOUNCE_CYCLES consecutive cycles. A revert restarts
   // the count.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_db <= '0;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (r_s2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DB_LAST) begin
               r_db[i]  <= r_s2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Per-player direction select. Priority is E > S > W > N. When no
   // direction is held, the player keeps its last heading.
   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic w_e;
      logic w_s;
      logic w_w;
      logic w_n;

      assign w_e = r_db[SRC_E*NUM_PLAYERS + p];
      assign w_s = r_db[SRC_S*NUM_PLAYERS + p];
      assign w_w = r_db[SRC_W*NUM_PLAYERS + p];
      assign w_n = r_db[SRC_N*NUM_PLAYERS + p];

      assign w_dir_next[2*p +: 2] = w_e ? DIR_E :
                                    w_s ? DIR_S :
                                    w_w ? DIR_W :
                                    w_n ? DIR_N : r_dir[2*p +: 2];

      assign w_dir_chg[p] = (w_dir_next[2*p +: 2] != r_dir[2*p +: 2]);
   end

   // Direction register and its change pulse. The pulse updates on the same
   // edge as the direction, so it is high exactly while the new value is
   // first visible.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_dir     <= '0;
         r_dir_chg <= '0;
      end else begin
         r_dir     <= w_dir_next;
         r_dir_chg <= w_dir_chg;
      end
   end

   // Any debounced pause rising edge causes one toggle. This holds even if
   // several players press in the same cycle.
   assign w_pause_db   = r_db[SRC_P*NUM_PLAYERS +: NUM_PLAYERS];
   assign w_pause_rise = |(w_pause_db & ~r_pause_prev);

   // Pause FSM (RUN <-> PAUSED) with a toggle pulse aligned to the state change.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pause_prev  <= '0;
         r_state       <= ST_RUN;
         r_pause_pulse <= 1'b0;
      end else begin
         r_pause_prev  <= w_pause_db;
         r_pause_pulse <= w_pause_rise;
         if (w_pause_rise) begin
            r_state <= (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
         end
      end
   end

   assign direction   = r_dir;
   assign dir_changed = r_dir_chg;
   assign paused      = (r_state == ST_PAUSED);
   assign pause_pulse = r_pause_pulse;

`ifdef GAME_INPUT_IDLE_EN
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

   logic [NB-1:0] r_db_prev;
   logic [NB-1:0] w_db_edge;

   // Previous debounced levels, used to detect activity on any input.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_db_prev <= '0;
      end else begin
         r_db_prev <= r_db;
      end
   end

   assign w_db_edge = r_db ^ r_db_prev;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_idle
      logic              w_act;
      logic [IDLE_W-1:0] r_idle_cnt;

      assign w_act = w_db_edge[SRC_E*NUM_PLAYERS + p] |
                     w_db_edge[SRC_S*NUM_PLAYERS + p] |
                     w_db_edge[SRC_W*NUM_PLAYERS + p] |
                     w_db_edge[SRC_N*NUM_PLAYERS + p] |
                     w_db_edge[SRC_P*NUM_PLAYERS + p];

      // Saturating inactivity counter. Any debounced edge from this player clears it.
      always_ff @(posedge clock) begin
         if (!resetn || w_act) begin
            r_idle_cnt <= '0;
         end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
         end
      end

      assign idle[p] = (r_idle_cnt >= IDLE_MAX);
   end
`else
   assign idle = '0;
`endif

endmodule
`default_nettype wire
